// File: rtl/mul32_karatsuba_seq.sv
// ---------------------------------------------------------------------------
// mul32_karatsuba_seq
//
// Shared wide multiplier: a 32x32 -> 64 unsigned product built by running one
// 16x16 combinational multiplier core over three Karatsuba passes:
//   z0 = aL*bL, z2 = aH*bH, zm = (aH+aL)*(bH+bL), z1 = zm - z0 - z2,
//   product = (z2 << 32) + (z1 << 16) + z0.
// One operation is in flight at a time. Operands are sampled only at
// acceptance. The product is held until the consumer takes it.
//
// Parameters:
//   PIPE_MUL  0: each pass takes 1 cycle (latency 4, one product / 5 cycles)
//             1: register after the 16x16 core, each pass takes 2 cycles
//                (latency 7)
//
// Build option:
//   MUL32_SEQ_ZERO_SKIP_EN  when defined, a zero operand at acceptance jumps
//                           straight to the combine state with a zero result
//                           (latency 1, core left idle).
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     operands valid
//   in_ready_o     block can accept operands (combinational from out_ready_i)
//   in_a_i         multiplicand, unsigned, 32 bit
//   in_b_i         multiplier, unsigned, 32 bit
//   out_valid_o    product valid
//   out_ready_i    consumer accepts product
//   out_product_o  in_a_i * in_b_i, 64 bit, holds its value after handshake
//   busy_o         high in any state other than idle
// ---------------------------------------------------------------------------
module mul32_karatsuba_seq #(
    parameter int unsigned PIPE_MUL = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_a_i,
    input  logic [31:0] in_b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_product_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StP0,
        StP1,
        StP2,
        StComb,
        StDone
    } state_e;

    state_e      state_q;

    // Captured operand halves.
    logic [15:0] a_hi_q;
    logic [15:0] a_lo_q;
    logic [15:0] b_hi_q;
    logic [15:0] b_lo_q;

    // Partial products.
    logic [31:0] z0_q;
    logic [31:0] z2_q;
    logic [33:0] zm_q;

    // Second-cycle marker for a pass when the core is pipelined.
    logic        wait_q;

    logic        out_valid_q;
    logic [63:0] out_product_q;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic accept;
    logic zero_op;

    assign in_ready_o = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

`ifdef MUL32_SEQ_ZERO_SKIP_EN
    assign zero_op = (in_a_i == 32'd0) || (in_b_i == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // 16x16 core and its operand mux
    // -----------------------------------------------------------------------
    // 17-bit sums for the middle pass; bit 16 is the carry handled outside
    // the 16x16 core.
    logic [16:0] sa;
    logic [16:0] sb;

    assign sa = {1'b0, a_hi_q} + {1'b0, a_lo_q};
    assign sb = {1'b0, b_hi_q} + {1'b0, b_lo_q};

    logic [15:0] core_a;
    logic [15:0] core_b;
    logic [31:0] core_p;
    logic [31:0] core_res;

    // Core inputs are parked at zero outside the passes to limit toggling.
    always_comb begin
        core_a = '0;
        core_b = '0;
        unique case (state_q)
            StP0: begin
                core_a = a_lo_q;
                core_b = b_lo_q;
            end
            StP1: begin
                core_a = a_hi_q;
                core_b = b_hi_q;
            end
            StP2: begin
                core_a = sa[15:0];
                core_b = sb[15:0];
            end
            default: begin
                core_a = '0;
                core_b = '0;
            end
        endcase
    end

    assign core_p = 32'(core_a) * 32'(core_b);

    generate
        if (PIPE_MUL != 0) begin : g_pipe
            logic [31:0] core_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    core_q <= '0;
                end else begin
                    core_q <= core_p;
                end
            end

            assign core_res = core_q;
        end else begin : g_comb
            assign core_res = core_p;
        end
    endgenerate

    // A pass latches on its only cycle (unpipelined) or its second cycle.
    logic pass_done;
    assign pass_done = (PIPE_MUL == 0) || wait_q;

    // -----------------------------------------------------------------------
    // Middle product and final combine
    // -----------------------------------------------------------------------
    // (sa)*(sb) with 17-bit sums = core(sa[15:0]*sb[15:0]) plus the cross
    // terms contributed by the carry bits.
    logic [33:0] zm_next;

    assign zm_next = {2'b00, core_res}
                   + (sa[16] ? {2'b00, sb[15:0], 16'h0000} : 34'd0)
                   + (sb[16] ? {2'b00, sa[15:0], 16'h0000} : 34'd0)
                   + {1'b0, sa[16] & sb[16], 32'h0000_0000};

    // True z1 is non-negative and fits in 33 bits; carrying 34 keeps the
    // arithmetic exact without dropping a bit of zm.
    logic [33:0] z1;
    logic [63:0] prod;

    assign z1   = zm_q - {2'b00, z0_q} - {2'b00, z2_q};
    assign prod = {z2_q, 32'h0000_0000}
                + {14'd0, z1, 16'h0000}
                + {32'h0000_0000, z0_q};

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            a_hi_q        <= '0;
            a_lo_q        <= '0;
            b_hi_q        <= '0;
            b_lo_q        <= '0;
            z0_q          <= '0;
            z2_q          <= '0;
            zm_q          <= '0;
            wait_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Output handshake completes; product value is kept.
                    if ((state_q == StDone) && out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        a_hi_q <= in_a_i[31:16];
                        a_lo_q <= in_a_i[15:0];
                        b_hi_q <= in_b_i[31:16];
                        b_lo_q <= in_b_i[15:0];
                        // Cleared partials make the combine state yield zero
                        // when the passes are skipped.
                        z0_q   <= '0;
                        z2_q   <= '0;
                        zm_q   <= '0;
                        wait_q <= 1'b0;
                        state_q <= zero_op ? StComb : StP0;
                    end else if ((state_q == StDone) && out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                StP0: begin
                    if (pass_done) begin
                        z0_q    <= core_res;
                        wait_q  <= 1'b0;
                        state_q <= StP1;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end
                StP1: begin
                    if (pass_done) begin
                        z2_q    <= core_res;
                        wait_q  <= 1'b0;
                        state_q <= StP2;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end
                StP2: begin
                    if (pass_done) begin
                        zm_q    <= zm_next;
                        wait_q  <= 1'b0;
                        state_q <= StComb;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end
                StComb: begin
                    out_product_q <= prod;
                    out_valid_q   <= 1'b1;
                    state_q       <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_product_o = out_product_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_mul32_karatsuba_seq.sv
// ---------------------------------------------------------------------------
// tb_mul32_karatsuba_seq
//
// Directed vectors with literal expected products and latencies, followed by
// a random stream. A transaction-level model (queue-free: one operation in
// flight) tracks acceptance, expected out_valid timing, in_ready, busy and the
// held product, and is compared against the DUT on every falling edge.
// PIPE_MUL and MUL32_SEQ_ZERO_SKIP_EN follow the DUT build.
// ---------------------------------------------------------------------------
module tb_mul32_karatsuba_seq;

    parameter int unsigned PIPE_MUL = 0;

    localparam int BASE_LAT = (PIPE_MUL != 0) ? 7 : 4;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = BASE_LAT;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic        busy;

    mul32_karatsuba_seq #(
        .PIPE_MUL (PIPE_MUL)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_a_i        (in_a),
        .in_b_i        (in_b),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_product_o (out_product),
        .busy_o        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    function automatic int lat_for(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL32_SEQ_ZERO_SKIP_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return BASE_LAT;
    endfunction

    bit          m_inflight  = 1'b0;
    int          m_acc_edge  = 0;
    int          m_lat       = 0;
    logic [63:0] m_prod      = '0;
    logic [63:0] m_last_prod = '0;
    int          n_acc       = 0;

    always @(negedge clk) begin
        bit          exp_valid;
        bit          exp_ready;
        logic [63:0] exp_out;
        if (!rst_n) begin
            m_inflight  = 1'b0;
            m_last_prod = '0;
        end
        exp_valid = m_inflight && (cyc >= m_acc_edge + m_lat);
        exp_ready = !m_inflight || (exp_valid && out_ready);
        exp_out   = exp_valid ? m_prod : m_last_prod;
        check(out_valid == exp_valid, "mon_out_valid", 64'(out_valid), 64'(exp_valid));
        check(in_ready == exp_ready, "mon_in_ready", 64'(in_ready), 64'(exp_ready));
        check(busy == m_inflight, "mon_busy", 64'(busy), 64'(m_inflight));
        check(out_product == exp_out, "mon_product", out_product, exp_out);
        if (rst_n) begin
            if (exp_valid && out_ready) begin
                m_inflight  = 1'b0;
                m_last_prod = m_prod;
            end
            if (in_valid && exp_ready) begin
                m_inflight = 1'b1;
                m_acc_edge = cyc + 1;
                m_lat      = lat_for(in_a, in_b);
                m_prod     = ref_mul(in_a, in_b);
                n_acc++;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Drivers (called and returning at posedge + 1)
    // ---------------------------------------------------------------------
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check(ok, "accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        // Scramble operands: they must have been sampled at acceptance.
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic recv(input logic [63:0] lit, input int lat_exp, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check(got, {name, "_timeout"}, 64'(got), 64'd1);
        if (got) begin
            check((cyc - acc_cyc) == lat_exp, {name, "_latency"},
                  64'(cyc - acc_cyc), 64'(lat_exp));
            check(out_product == lit, {name, "_product"}, out_product, lit);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(7, 0))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return r & 32'h0000_00FF;
            3: return {r[31:16], 16'hFFFF};
            4: return {16'hFFFF, r[15:0]};
            default: return r;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int start_acc;
        int budget;
        bit drained;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        check(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        check(busy == 1'b0, "reset_busy", 64'(busy), 64'd0);
        check(out_product == 64'd0, "reset_product", out_product, 64'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        send(32'd3, 32'd5);
        recv(64'h0000_0000_0000_000F, BASE_LAT, "small_3x5");

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        recv(64'hFFFF_FFFE_0000_0001, BASE_LAT, "max_x_max");

        send(32'h0001_0000, 32'h0001_0000);
        recv(64'h0000_0001_0000_0000, BASE_LAT, "bit16_sq");

        send(32'h1234_5678, 32'h9ABC_DEF0);
        recv(64'h0B00_EA4E_242D_2080, BASE_LAT, "mixed");

        // Backpressure, then back-to-back acceptance on the releasing cycle.
        out_ready = 1'b0;
        send(32'd7, 32'd9);
        recv(64'd63, BASE_LAT, "bp_7x9");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check(out_valid == 1'b1, "bp_hold_valid", 64'(out_valid), 64'd1);
            check(out_product == 64'd63, "bp_hold_product", out_product, 64'd63);
            check(in_ready == 1'b0, "bp_hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'd2, 32'd4);
        recv(64'd8, BASE_LAT, "bp_next_2x4");

        // Reset while the high-half pass is running.
        send(32'hAAAA_5555, 32'd3);
        repeat ((PIPE_MUL != 0) ? 2 : 1) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
            check(busy == 1'b0, "midrst_busy", 64'(busy), 64'd0);
            check(in_ready == 1'b1, "midrst_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check(out_valid == 1'b0, "abandoned_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'd1);
        recv(64'h0000_0000_1234_5678, BASE_LAT, "after_reset");

        send(32'd0, 32'hDEAD_BEEF);
        recv(64'd0, ZERO_LAT, "zero_a");
        send(32'hDEAD_BEEF, 32'd0);
        recv(64'd0, ZERO_LAT, "zero_b");

        // Random stream: random valid/ready, operands changing every cycle.
        start_acc = n_acc;
        budget    = 0;
        while ((n_acc - start_acc) < 1000 && budget < 40000) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            in_a      = rnd_operand();
            in_b      = rnd_operand();
            out_ready = ($urandom_range(3, 0) != 0);
            @(posedge clk);
            #1;
            budget++;
        end
        check((n_acc - start_acc) >= 1000, "random_budget",
              64'(n_acc - start_acc), 64'd1000);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        drained   = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) begin
                drained = 1'b1;
                break;
            end
        end
        check(drained, "drain_timeout", 64'(drained), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
